go_delay_scheduler: RTL
=======================

Name: go_delay_scheduler

Overview:
- Time-shares one go-delay counter between N_REQ requesters. Each requester owns a go/kill pair, matching the existing per-channel go/kill/done convention.
- Round-robin arbiter grants one requester at a time and runs the shared delay. It then reports completion or abort to that requester.
- Sits between the channel request logic and downstream done consumers. It replaces one counter instance per channel with a single shared one.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DELAY, 4, cycles spent in RUN per grant (>=1).
- CNT_W, $clog2(DELAY+1), counter width (derived, do not override).

Ports:
- i_clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_req  input  N_REQ  level request per channel.
- i_kill  input  N_REQ  abort request per channel.
- i_kill_clr  input  1  clears kill latch (see Optional Feature).
- o_grant  output  N_REQ  one-hot owner of the counter, all-zero when idle.
- o_done  output  N_REQ  one-cycle completion pulse to the owner.
- o_abort  output  N_REQ  one-cycle abort pulse to the owner.
- o_busy  output  1  high in RUN and DONE.
- o_kill_ltchd  output  1  sticky kill indicator.

Behaviour:
- Reset (reset_n low, async): state=IDLE, cnt=0, o_grant=0, o_done=0, o_abort=0, o_busy=0, o_kill_ltchd=0. The RR pointer is set so channel 0 has top priority.
- All outputs are registered.
- States:
  - IDLE: eligible = i_req & ~i_kill. If eligible≠0, grant the first set bit at or after the RR pointer, wrapping. Load cnt=DELAY-1 and go to RUN. Advance the pointer to grant index+1 mod N_REQ. If eligible=0, stay in IDLE.
  - RUN: if i_kill[owner]=1, go to IDLE next cycle, pulse o_abort[owner] in that IDLE cycle, and clear o_grant. Kill has priority over cnt==0. Otherwise, if cnt==0 go to DONE, else cnt=cnt-1.
  - DONE: o_done[owner]=1 for exactly this cycle, o_grant held. Next state is IDLE unconditionally.
- Latency: req seen in IDLE on cycle 0 gives o_grant from cycle 1 through DELAY+1. o_done is pulsed on cycle DELAY+1. IDLE is re-entered on cycle DELAY+2, so the earliest next grant is cycle DELAY+3.
- i_req is not sampled outside IDLE. Dropping req mid-RUN does not abort; only i_kill aborts.
- i_kill on a non-owner channel during RUN/DONE is ignored by the scheduler, but it still sets the kill latch.
- i_kill during DONE is ignored; the done pulse is still issued.
- Simultaneous requests resolve round-robin. A requester holding req continuously is re-granted only after the others have been served.
- Async reset mid-RUN: outputs drop immediately, and no done/abort pulse is emitted.
- o_done and o_abort are never high in the same cycle, and are never high for a non-owner.

Optional Feature:
- Macro KILL_LATCH_EN.
- Defined: o_kill_ltchd sets on any i_kill bit in any state. It holds until i_kill_clr=1. Clear wins over a same-cycle kill. Reset clears it.
- Undefined: o_kill_ltchd is tied 0, i_kill_clr is ignored, and the latch flop is not built.

Test Plan:
- DELAY=4, i_req=001 at cycle 0 then held → o_grant=001 cycles 1-5, o_done=001 cycle 5 only, o_busy low cycle 6, re-grant 001 from cycle 7.
- i_req=111 held → grant order 001,010,100,001, each DELAY+1 cycles long, one done pulse per grant.
- Grant 010, i_kill=010 on cycle 2 → o_abort=010 cycle 3, o_grant=000 cycle 3, no o_done. Next grant goes to 100 when requested.
- i_req=011 and i_kill=001 in the same IDLE cycle → grant 010. Channel 0 is skipped that cycle.
- KILL_LATCH_EN defined: i_kill=100 while 001 owns the counter → o_kill_ltchd=1 next cycle, and 001 still completes. i_kill_clr together with i_kill → o_kill_ltchd=0.
- reset_n low on cycle 3 of RUN → all outputs 0 immediately. After release with i_req=010, grant 010 one cycle later.

Source files
------------

// File: rtl/go_delay_scheduler.sv
// Round-robin scheduler that time-shares one go-delay counter between N_REQ go/kill requesters.
// Optional sticky kill indicator is built only when KILL_LATCH_EN is defined.
module go_delay_scheduler #(
    parameter int N_REQ = 3,
    parameter int DELAY = 4
) (
    input  logic             i_clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_kill,
    input  logic             i_kill_clr,
    output logic [N_REQ-1:0] o_grant,
    output logic [N_REQ-1:0] o_done,
    output logic [N_REQ-1:0] o_abort,
    output logic             o_busy,
    output logic             o_kill_ltchd
);

    localparam int CNT_W = $clog2(DELAY + 1);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GRANT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   owner_r;
    logic [N_REQ-1:0]   grant_r;
    logic [N_REQ-1:0]   done_r;
    logic [N_REQ-1:0]   abort_r;
    logic               busy_r;

    logic [N_REQ-1:0]   eligible_s;
    logic [IDX_W-1:0]   cand_s;
    logic [IDX_W-1:0]   pick_s;
    logic               found_s;
    int                 sum_s;

    // Round-robin search: first eligible channel at or after the pointer, wrapping
    always_comb begin
        eligible_s = i_req & ~i_kill;
        found_s    = 1'b0;
        pick_s     = '0;
        cand_s     = '0;
        sum_s      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_s  = int'(ptr_r) + i;
            sum_s  = (sum_s >= N_REQ) ? (sum_s - N_REQ) : sum_s;
            cand_s = IDX_W'(sum_s);
            if (!found_s && eligible_s[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Scheduler FSM with registered grant/done/abort/busy
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            ptr_r   <= '0;
            owner_r <= '0;
            grant_r <= '0;
            done_r  <= '0;
            abort_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            done_r  <= '0;
            abort_r <= '0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r <= RUN;
                        cnt_r   <= CNT_W'(DELAY - 1);
                        owner_r <= pick_s;
                        grant_r <= GRANT_LSB << pick_s;
                        busy_r  <= 1'b1;
                        ptr_r   <= (pick_s == LAST_IDX) ? IDX_W'(0) : (pick_s + IDX_W'(1));
                    end else begin
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    // Owner kill outranks the terminal count
                    if (i_kill[owner_r]) begin
                        state_r <= IDLE;
                        abort_r <= grant_r;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_W'(0)) begin
                        state_r <= DONE;
                        done_r  <= grant_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant = grant_r;
    assign o_done  = done_r;
    assign o_abort = abort_r;
    assign o_busy  = busy_r;

`ifdef KILL_LATCH_EN
    logic kill_ltchd_r;

    // Sticky record of any kill; clear wins over a same-cycle kill
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            kill_ltchd_r <= 1'b0;
        end else if (i_kill_clr) begin
            kill_ltchd_r <= 1'b0;
        end else if (|i_kill) begin
            kill_ltchd_r <= 1'b1;
        end else begin
            kill_ltchd_r <= kill_ltchd_r;
        end
    end

    assign o_kill_ltchd = kill_ltchd_r;
`else
    logic unused_kill_clr_s;
    assign unused_kill_clr_s = i_kill_clr;
    assign o_kill_ltchd      = 1'b0;
`endif

endmodule
